// File: rtl/age_issue_queue_if.sv
// age_issue_queue_if: renamer, wakeup, PRF and FU signals of the age-ordered issue queue
interface age_issue_queue_if #(
  parameter int INST_ID_BITS = 6,
  parameter int PRN_BITS = 6,
  parameter int MAX_OPERANDS = 3,
  parameter int QUEUE_SIZE = 8,
  parameter int WAKEUP_PORTS = 4
);
  logic in_valid;
  logic in_ready;
  logic [INST_ID_BITS-1:0] in_inst_id;
  logic [31:0] in_inst;
  logic [63:0] in_pc;
  logic [MAX_OPERANDS-1:0] in_op_valid;
  logic [MAX_OPERANDS-1:0] in_op_ready;
  logic [PRN_BITS-1:0] in_op_prn [MAX_OPERANDS];
  logic [PRN_BITS-1:0] in_out_prn [MAX_OPERANDS];
  logic [WAKEUP_PORTS-1:0] wakeup_valid;
  logic [PRN_BITS-1:0] wakeup_prn [WAKEUP_PORTS];
  logic flush;
  logic [MAX_OPERANDS-1:0] prf_read_enable;
  logic [PRN_BITS-1:0] prf_read_prn [MAX_OPERANDS];
  logic [63:0] prf_op [MAX_OPERANDS];
  logic out_valid;
  logic out_ready;
  logic [INST_ID_BITS-1:0] out_inst_id;
  logic [31:0] out_inst;
  logic [63:0] out_pc;
  logic [63:0] out_op [MAX_OPERANDS];
  logic [PRN_BITS-1:0] out_out_prn [MAX_OPERANDS];
  logic [$clog2(QUEUE_SIZE+1)-1:0] occupancy;
  modport master (
    output in_valid, in_inst_id, in_inst, in_pc, in_op_valid, in_op_ready, in_op_prn, in_out_prn,
           wakeup_valid, wakeup_prn, flush, prf_op, out_ready,
    input  in_ready, prf_read_enable, prf_read_prn, out_valid, out_inst_id, out_inst, out_pc,
           out_op, out_out_prn, occupancy
  );
  modport slave (
    input  in_valid, in_inst_id, in_inst, in_pc, in_op_valid, in_op_ready, in_op_prn, in_out_prn,
           wakeup_valid, wakeup_prn, flush, prf_op, out_ready,
    output in_ready, prf_read_enable, prf_read_prn, out_valid, out_inst_id, out_inst, out_pc,
           out_op, out_out_prn, occupancy
  );
endinterface

// File: rtl/age_issue_queue.sv
// age_issue_queue: oldest-ready-first reservation station with skid output, flush and occupancy; IQ_WAKEUP_BYPASS_EN adds insert-time wakeup capture
module age_issue_queue #(
  parameter int INST_ID_BITS = 6,
  parameter int PRN_BITS = 6,
  parameter int MAX_OPERANDS = 3,
  parameter int QUEUE_SIZE = 8,
  parameter int WAKEUP_PORTS = 4
) (
  input logic clk,
  input logic rst,
  age_issue_queue_if.slave q
);
  localparam int QS = QUEUE_SIZE;
  localparam int MO = MAX_OPERANDS;
  localparam int IW = $clog2(QS);
  localparam int OW = $clog2(QS+1);
  logic [QS-1:0] valid_q;
  logic [QS-1:0] older_q [QS];
  logic [INST_ID_BITS-1:0] id_q [QS];
  logic [31:0] inst_q [QS];
  logic [63:0] pc_q [QS];
  logic [MO-1:0] opv_q [QS];
  logic [MO-1:0] opr_q [QS];
  logic [PRN_BITS-1:0] prn_q [QS][MO];
  logic [PRN_BITS-1:0] oprn_q [QS][MO];
  logic out_valid_q;
  logic [INST_ID_BITS-1:0] out_id_q;
  logic [31:0] out_inst_q;
  logic [63:0] out_pc_q;
  logic [63:0] out_op_q [MO];
  logic [PRN_BITS-1:0] out_oprn_q [MO];
  logic [OW-1:0] occ_q;
  logic [MO-1:0] wake_hit [QS];
  logic [MO-1:0] in_rdy;
  logic [QS-1:0] rdy;
  logic [QS-1:0] sel;
  logic [IW-1:0] sel_idx;
  logic [IW-1:0] ins_idx;
  logic do_issue;
  logic do_ins;
  // broadcast match of every wakeup port against every stored operand slot
  always_comb begin
    for (int i = 0; i < QS; i++) begin
      wake_hit[i] = '0;
      for (int j = 0; j < MO; j++)
        for (int k = 0; k < WAKEUP_PORTS; k++)
          wake_hit[i][j] = wake_hit[i][j] | (q.wakeup_valid[k] && q.wakeup_prn[k] == prn_q[i][j] && opv_q[i][j]);
    end
  end
`ifdef IQ_WAKEUP_BYPASS_EN
  // a wakeup coincident with insert is captured into the new entry
  always_comb begin
    in_rdy = q.in_op_ready;
    for (int j = 0; j < MO; j++)
      for (int k = 0; k < WAKEUP_PORTS; k++)
        in_rdy[j] = in_rdy[j] | (q.wakeup_valid[k] && q.wakeup_prn[k] == q.in_op_prn[j]);
  end
`else
  assign in_rdy = q.in_op_ready;
`endif
  // oldest ready entry wins: selected when no other ready entry is older than it
  always_comb begin
    sel = '0;
    sel_idx = '0;
    ins_idx = '0;
    for (int i = 0; i < QS; i++) rdy[i] = valid_q[i] && &(~opv_q[i] | opr_q[i]);
    for (int i = 0; i < QS; i++) begin
      sel[i] = rdy[i];
      for (int j = 0; j < QS; j++) if (rdy[j] && older_q[j][i]) sel[i] = 1'b0;
      if (sel[i]) sel_idx = IW'(i);
    end
    for (int i = QS-1; i >= 0; i--) if (!valid_q[i]) ins_idx = IW'(i);
    do_issue = |rdy && (!out_valid_q || q.out_ready) && !q.flush;
    do_ins = q.in_valid && !(&valid_q) && !q.flush;
  end
  // PRF read port addresses the issuing entry's sources in the issue cycle
  always_comb begin
    for (int j = 0; j < MO; j++) begin
      q.prf_read_enable[j] = do_issue && opv_q[sel_idx][j];
      q.prf_read_prn[j] = do_issue ? prn_q[sel_idx][j] : '0;
    end
  end
  // entry storage, wakeup capture, age matrix and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      occ_q <= '0;
      for (int i = 0; i < QS; i++) older_q[i] <= '0;
    end else if (q.flush) begin
      valid_q <= '0;
      occ_q <= '0;
    end else begin
      for (int i = 0; i < QS; i++)
        if (valid_q[i]) opr_q[i] <= opr_q[i] | wake_hit[i];
      if (do_issue) valid_q[sel_idx] <= 1'b0;
      if (do_ins) begin
        valid_q[ins_idx] <= 1'b1;
        id_q[ins_idx] <= q.in_inst_id;
        inst_q[ins_idx] <= q.in_inst;
        pc_q[ins_idx] <= q.in_pc;
        opv_q[ins_idx] <= q.in_op_valid;
        opr_q[ins_idx] <= in_rdy;
        for (int j = 0; j < MO; j++) begin
          prn_q[ins_idx][j] <= q.in_op_prn[j];
          oprn_q[ins_idx][j] <= q.in_out_prn[j];
        end
        older_q[ins_idx] <= '0;
        for (int k = 0; k < QS; k++) if (k != int'(ins_idx)) older_q[k][ins_idx] <= 1'b1;
      end
      occ_q <= occ_q + OW'(do_ins) - OW'(do_issue);
    end
  end
  // output skid register: load on issue, hold on stall, clear on consume
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_id_q <= '0;
      out_inst_q <= '0;
      out_pc_q <= '0;
      for (int j = 0; j < MO; j++) begin
        out_op_q[j] <= '0;
        out_oprn_q[j] <= '0;
      end
    end else if (q.flush) begin
      out_valid_q <= 1'b0;
    end else if (do_issue) begin
      out_valid_q <= 1'b1;
      out_id_q <= id_q[sel_idx];
      out_inst_q <= inst_q[sel_idx];
      out_pc_q <= pc_q[sel_idx];
      for (int j = 0; j < MO; j++) begin
        out_op_q[j] <= opv_q[sel_idx][j] ? q.prf_op[j] : '0;
        out_oprn_q[j] <= oprn_q[sel_idx][j];
      end
    end else if (q.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end
  assign q.in_ready = !(&valid_q);
  assign q.out_valid = out_valid_q;
  assign q.out_inst_id = out_id_q;
  assign q.out_inst = out_inst_q;
  assign q.out_pc = out_pc_q;
  assign q.out_op = out_op_q;
  assign q.out_out_prn = out_oprn_q;
  assign q.occupancy = occ_q;
endmodule

// File: tb/tb_age_issue_queue.sv
// tb_age_issue_queue: directed checks of ordering, stall, full, flush, wakeup and reset
module tb_age_issue_queue;
  logic clk;
  logic rst;
  int n_chk = 0;
  int n_err = 0;
  age_issue_queue_if bus ();
  age_issue_queue dut (.clk(clk), .rst(rst), .q(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // PRF model: slot j returns 0x100*(j+1) + prn
  always_comb
    for (int j = 0; j < 3; j++) bus.prf_op[j] = 64'(j+1) * 64'h100 + 64'(bus.prf_read_prn[j]);
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic put(input int id, input logic [2:0] opv, input logic [2:0] opr, input int p0, input int p1, input int p2);
    bus.in_valid = 1'b1;
    bus.in_inst_id = 6'(id);
    bus.in_inst = 32'(id) << 4;
    bus.in_pc = 64'h1000 + 64'(id);
    bus.in_op_valid = opv;
    bus.in_op_ready = opr;
    bus.in_op_prn[0] = 6'(p0);
    bus.in_op_prn[1] = 6'(p1);
    bus.in_op_prn[2] = 6'(p2);
    for (int j = 0; j < 3; j++) bus.in_out_prn[j] = 6'(id + j);
  endtask
  task automatic idle;
    bus.in_valid = 1'b0;
  endtask
  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_inst_id = '0;
    bus.in_inst = '0;
    bus.in_pc = '0;
    bus.in_op_valid = '0;
    bus.in_op_ready = '0;
    for (int j = 0; j < 3; j++) begin
      bus.in_op_prn[j] = '0;
      bus.in_out_prn[j] = '0;
    end
    bus.wakeup_valid = '0;
    for (int k = 0; k < 4; k++) bus.wakeup_prn[k] = '0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    tick;
    tick;
    rst = 1'b0;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_occ", 64'(bus.occupancy), 64'd0);
    chk("rst_prf_en", 64'(bus.prf_read_enable), 64'd0);
    bus.out_ready = 1'b1;
    put(1, 3'b001, 3'b000, 5, 0, 0);
    tick;
    put(2, 3'b011, 3'b011, 10, 11, 0);
    chk("a_not_ready_en", 64'(bus.prf_read_enable), 64'd0);
    tick;
    put(3, 3'b100, 3'b100, 0, 0, 20);
    chk("b_sel_en", 64'(bus.prf_read_enable), 64'b011);
    chk("b_sel_prn0", 64'(bus.prf_read_prn[0]), 64'd10);
    tick;
    idle;
    chk("b_out_valid", 64'(bus.out_valid), 64'd1);
    chk("b_out_id", 64'(bus.out_inst_id), 64'd2);
    chk("b_op0", bus.out_op[0], 64'h10a);
    chk("b_op1", bus.out_op[1], 64'h20b);
    chk("b_op2_unused", bus.out_op[2], 64'h0);
    chk("b_pc", bus.out_pc, 64'h1002);
    chk("b_out_prn1", 64'(bus.out_out_prn[1]), 64'd3);
    chk("b_occ", 64'(bus.occupancy), 64'd2);
    tick;
    chk("c_out_id", 64'(bus.out_inst_id), 64'd3);
    chk("c_op2", bus.out_op[2], 64'h314);
    chk("c_op0_unused", bus.out_op[0], 64'h0);
    chk("c_occ", 64'(bus.occupancy), 64'd1);
    bus.wakeup_valid[3] = 1'b1;
    bus.wakeup_prn[3] = 6'd5;
    tick;
    bus.wakeup_valid = '0;
    chk("wake_gap_valid", 64'(bus.out_valid), 64'd0);
    chk("a_sel_en", 64'(bus.prf_read_enable), 64'b001);
    tick;
    chk("a_out_id", 64'(bus.out_inst_id), 64'd1);
    chk("a_op0", bus.out_op[0], 64'h105);
    chk("a_op1_unused", bus.out_op[1], 64'h0);
    chk("a_occ", 64'(bus.occupancy), 64'd0);
    tick;
    chk("drain_valid", 64'(bus.out_valid), 64'd0);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      put(10 + i, 3'b001, 3'b001, i, 0, 0);
      tick;
    end
    idle;
    chk("stall_occ7", 64'(bus.occupancy), 64'd7);
    chk("stall_in_ready", 64'(bus.in_ready), 64'd1);
    chk("stall_out_id", 64'(bus.out_inst_id), 64'd10);
    chk("stall_op0", bus.out_op[0], 64'h100);
    chk("stall_prf_en", 64'(bus.prf_read_enable), 64'd0);
    put(18, 3'b001, 3'b001, 8, 0, 0);
    tick;
    chk("full_occ8", 64'(bus.occupancy), 64'd8);
    chk("full_in_ready", 64'(bus.in_ready), 64'd0);
    put(19, 3'b001, 3'b001, 9, 0, 0);
    tick;
    idle;
    chk("full_ignored_occ", 64'(bus.occupancy), 64'd8);
    chk("hold_out_id", 64'(bus.out_inst_id), 64'd10);
    bus.out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick;
      chk($sformatf("order_id%0d", k), 64'(bus.out_inst_id), 64'(10 + k));
      chk($sformatf("order_op%0d", k), bus.out_op[0], 64'h100 + 64'(k));
    end
    chk("order_occ0", 64'(bus.occupancy), 64'd0);
    tick;
    chk("order_done", 64'(bus.out_valid), 64'd0);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      put(20 + i, 3'b001, 3'b001, i, 0, 0);
      tick;
    end
    idle;
    chk("t6_occ8", 64'(bus.occupancy), 64'd8);
    chk("t6_out_id", 64'(bus.out_inst_id), 64'd20);
    bus.out_ready = 1'b1;
    put(29, 3'b001, 3'b001, 29, 0, 0);
    chk("t6_in_ready0", 64'(bus.in_ready), 64'd0);
    tick;
    chk("t6_occ7", 64'(bus.occupancy), 64'd7);
    chk("t6_out_id21", 64'(bus.out_inst_id), 64'd21);
    bus.out_ready = 1'b0;
    chk("t6_in_ready1", 64'(bus.in_ready), 64'd1);
    tick;
    idle;
    chk("t6_refill_occ", 64'(bus.occupancy), 64'd8);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick;
      chk($sformatf("t6_order%0d", k), 64'(bus.out_inst_id), 64'(22 + k));
    end
    tick;
    chk("t6_done", 64'(bus.out_valid), 64'd0);
    chk("t6_occ0", 64'(bus.occupancy), 64'd0);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      put(30 + i, 3'b001, 3'b001, i, 0, 0);
      tick;
    end
    idle;
    chk("fl_pre_occ", 64'(bus.occupancy), 64'd3);
    chk("fl_pre_valid", 64'(bus.out_valid), 64'd1);
    put(34, 3'b001, 3'b001, 4, 0, 0);
    bus.flush = 1'b1;
    tick;
    bus.flush = 1'b0;
    idle;
    chk("fl_occ", 64'(bus.occupancy), 64'd0);
    chk("fl_valid", 64'(bus.out_valid), 64'd0);
    bus.out_ready = 1'b1;
    tick;
    chk("fl_no_insert", 64'(bus.out_valid), 64'd0);
    chk("fl_occ_after", 64'(bus.occupancy), 64'd0);
    chk("fl_in_ready", 64'(bus.in_ready), 64'd1);
    put(40, 3'b001, 3'b000, 9, 0, 0);
    bus.wakeup_valid[0] = 1'b1;
    bus.wakeup_prn[0] = 6'd9;
    tick;
    idle;
    bus.wakeup_valid = '0;
    tick;
`ifdef IQ_WAKEUP_BYPASS_EN
    chk("byp_valid", 64'(bus.out_valid), 64'd1);
    chk("byp_id", 64'(bus.out_inst_id), 64'd40);
    chk("byp_op0", bus.out_op[0], 64'h109);
`else
    chk("nobyp_valid", 64'(bus.out_valid), 64'd0);
    chk("nobyp_occ", 64'(bus.occupancy), 64'd1);
    bus.wakeup_valid[1] = 1'b1;
    bus.wakeup_prn[1] = 6'd9;
    tick;
    bus.wakeup_valid = '0;
    tick;
    chk("nobyp_late_valid", 64'(bus.out_valid), 64'd1);
    chk("nobyp_late_id", 64'(bus.out_inst_id), 64'd40);
    chk("nobyp_late_op0", bus.out_op[0], 64'h109);
`endif
    tick;
    bus.out_ready = 1'b0;
    put(50, 3'b001, 3'b001, 1, 0, 0);
    tick;
    put(51, 3'b001, 3'b001, 2, 0, 0);
    tick;
    idle;
    chk("rst2_pre_valid", 64'(bus.out_valid), 64'd1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rst2_occ", 64'(bus.occupancy), 64'd0);
    chk("rst2_valid", 64'(bus.out_valid), 64'd0);
    chk("rst2_out_id", 64'(bus.out_inst_id), 64'd0);
    chk("rst2_in_ready", 64'(bus.in_ready), 64'd1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/age_issue_queue.md
Name: age_issue_queue

Overview:
Next-generation reservation station between the renamer and one functional unit. Instructions are held until all of their operands are ready, then issued in oldest-first order. Compared with the first-generation queue it adds:
- configurable depth and number of wakeup ports, with any wakeup port able to wake any operand slot
- a valid/ready skid output toward the FU
- a pipeline flush
- an occupancy count

Parameters:
INST_ID_BITS, 6, instruction tag width
PRN_BITS, 6, physical register number width
MAX_OPERANDS, 3, source/destination operand slots per instruction
QUEUE_SIZE, 8, entries; any value >= 2 (power of 2 not required)
WAKEUP_PORTS, 4, PRN-ready broadcast ports

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  renamer offers an instruction
in_ready  out  1  free entry exists; insert occurs on in_valid && in_ready
in_inst_id  in  INST_ID_BITS  tag
in_inst  in  32  raw instruction
in_pc  in  64  PC
in_op_valid[MAX_OPERANDS]  in  1  operand slot used
in_op_ready[MAX_OPERANDS]  in  1  operand already in PRF
in_op_prn[MAX_OPERANDS]  in  PRN_BITS  source PRN
in_out_prn[MAX_OPERANDS]  in  PRN_BITS  destination PRNs, passed through
wakeup_valid[WAKEUP_PORTS]  in  1  broadcast valid
wakeup_prn[WAKEUP_PORTS]  in  PRN_BITS  PRN now ready
flush  in  1  discard all queued and output-staged work
prf_read_enable[MAX_OPERANDS]  out  1  PRF read strobe (combinational)
prf_read_prn[MAX_OPERANDS]  out  PRN_BITS  PRF read address (combinational)
prf_op[MAX_OPERANDS]  in  64  PRF read data, same cycle
out_valid  out  1  issue slot holds an instruction
out_ready  in  1  FU accepts; transfer on out_valid && out_ready
out_inst_id  out  INST_ID_BITS; out_inst  out  32; out_pc  out  64
out_op[MAX_OPERANDS]  out  64  operand values
out_out_prn[MAX_OPERANDS]  out  PRN_BITS
occupancy  out  $clog2(QUEUE_SIZE+1)  valid entries (registered)

Behaviour:
- Reset, synchronous: all entries invalid; out_valid=0; all out_* fields=0; occupancy=0; age state cleared.
- After reset: in_ready=1 and prf_read_enable=0.
- Entry ready when: valid, and for every slot, !op_valid || op_ready.
- Wakeup:
  - On each edge, every valid entry sets op_ready[j] if any port k has wakeup_valid[k] && wakeup_prn[k]==op_prn[j] && op_valid[j].
  - All ports are compared against all slots.
- Select (combinational):
  - Picks the ready entry inserted earliest (true age order, independent of slot index).
  - Ties are impossible: one insert per cycle.
- Issue:
  - Occurs when a ready entry exists and (!out_valid || out_ready).
  - prf_read_enable[j] = op_valid[j] of the selected entry; prf_read_prn = its op_prn.
  - Otherwise all enables=0 and prns=0.
  - At the edge: out_* load from the selected entry; out_op[j] = prf_op[j] if op_valid[j], else 64'h0; out_valid=1; the entry is invalidated.
- Hold: out_valid && !out_ready holds all out_* stable and issues nothing.
- Consume without replacement: out_valid clears.
- Latency: an instruction inserted at edge N with all operands ready is visible on out_valid after edge N+1, given no older ready entry and no stall.
- Wakeup-to-issue latency: 1 cycle after the broadcast edge.
- Insert:
  - Goes to the lowest-index free slot.
  - in_ready reflects only slots free at cycle start; a slot vacated by this cycle's issue is not reusable until the next cycle.
  - Full queue: in_ready=0, and in_valid is ignored.
- Simultaneous issue and insert: both happen; occupancy net unchanged.
- Age state: the inserted entry becomes youngest; issuing an entry removes it from age state without reordering the others.
- occupancy: +1 on insert, -1 on issue, registered.
- Flush (priority over insert, issue and wakeup):
  - Next cycle all entries invalid, out_valid=0, occupancy=0.
  - An in_valid && in_ready in the flush cycle is dropped.
  - out_* data is don't-care after flush.
- rst asserted mid-stall or mid-flush behaves identically to reset.

Optional Feature:
IQ_WAKEUP_BYPASS_EN.
- Defined: insert logic compares in_op_prn against the same-cycle wakeup ports. A match stores op_ready=1 even when in_op_ready=0.
- Undefined: in_op_ready is stored as given, and a wakeup coincident with insert is lost. The renamer must then guarantee that no wakeup for a PRN coincides with insert of a consumer of that PRN.

Test Plan:
1. Reset -> in_ready=1, out_valid=0, occupancy=0, prf_read_enable all 0.
2. Insert A (op0 prn 5 not ready), then B, then C (both ready), out_ready=1 -> B issues, then C. Then wakeup prn 5 on port 3 -> A issues one cycle later. out_op[j]=0 for unused slots.
3. Insert 8 ready instructions with out_ready=0 -> first appears on out and holds stable; occupancy 7, in_ready=1. Insert one more -> occupancy 8, in_ready=0; ninth in_valid is ignored. Raise out_ready -> remaining issue in insert order.
4. Queue holding 3 entries, out_valid=1 -> pulse flush together with in_valid -> next cycle occupancy=0, out_valid=0, and the in-flight insert is absent.
5. Insert with in_op_ready=0 for prn 9 while wakeup_prn[0]=9 in the same cycle -> with macro: issues the next cycle. Without macro: stays queued until a later wakeup.
6. Full queue, issue and insert in the same cycle -> in_ready was 0, so no insert; occupancy 7. Next cycle: in_ready=1, insert lands in the freed slot.
